bios_flash_failover_ctrl: RTL

Dual-BIOS flash failover and update sequencer for the BMU CPLD. It watches the BMC heartbeat inside a post-reset boot window and accepts update requests from the I2C register bank. It steers the single QSPI chip-select to the main or second flash, and issues a timed CPU POR pulse on every boot-image change. It replaces ad-hoc state/LED logic at the top level and drives the QSPI CS pins, the LEDs and the POR-request input of the POR driver.

---
 rtl/bios_flash_failover_ctrl.sv | 109 ++++++++++
 1 files changed

// File: rtl/bios_flash_failover_ctrl.sv
// bios_flash_failover_ctrl: dual-BIOS failover/update sequencer with CPU POR pulse and QSPI CS steering
`timescale 1ns/1ps
module bios_flash_failover_ctrl #(
  parameter int BOOT_TIMEOUT_S = 150,
  parameter int HB_LOSS_MS     = 2000,
  parameter int POR_PULSE_MS   = 100
) (
  input  logic       clk,
  input  logic       rst_l,
  input  logic       tick_1ms,
  input  logic       tick_1s,
  input  logic       heartbeat,
  input  logic       boot_rst_n,
  input  logic       upd_main_n,
  input  logic       upd_second_n,
  input  logic       upd_done_n,
  input  logic       qspi_csn_in,
  output logic       qspi_csn0_out,
  output logic       qspi_csn1_out,
  output logic       por_n,
  output logic [1:0] state,
  output logic       fatal
);
  typedef enum logic [1:0] {MAIN_BOOT, SECOND_BOOT, UPD_MAIN, UPD_SECOND} state_t;
  localparam logic [11:0] HB_MAX  = 12'(HB_LOSS_MS);
  localparam logic [7:0]  WIN_MAX = 8'(BOOT_TIMEOUT_S);
  localparam logic [7:0]  POR_MAX = 8'(POR_PULSE_MS);
  state_t      state_q, state_d;
  logic [5:0]  sync1_q, sync2_q;
  logic [3:0]  prev_q;
  logic [11:0] hb_cnt_q, hb_cnt_d;
  logic [7:0]  win_cnt_q, win_cnt_d, por_cnt_q, por_cnt_d;
  logic [2:0]  req_q, req_d, upd_fall;
  logic        por_n_q, por_n_d, fatal_q, fatal_d, sel_q, sel_d;
  logic        hb_s, boot_s, csn_s, hb_lost, win_done, fire, sel, gap;
  // Sync bit order {heartbeat, boot_rst_n, csn, upd_main, upd_second, upd_done}; req bits {main, second, done}
  assign {hb_s, boot_s, csn_s} = sync2_q[5:3];
  assign upd_fall = prev_q[2:0] & ~sync2_q[2:0];
  assign hb_lost  = hb_cnt_q == HB_MAX;
  assign win_done = win_cnt_q == WIN_MAX;
  assign sel      = state_q[0];
  assign gap      = sel != sel_q;
  assign qspi_csn0_out = gap | sel_q | qspi_csn_in;
  assign qspi_csn1_out = gap | ~sel_q | qspi_csn_in;
  assign por_n = por_n_q;
  assign state = state_q;
  assign fatal = fatal_q;
  // Heartbeat-loss and boot-window timers, both frozen at zero while POR is asserted
  always_comb begin
    hb_cnt_d  = (hb_s != prev_q[3] || !por_n_q) ? '0 : (tick_1ms && !hb_lost) ? hb_cnt_q + 12'd1 : hb_cnt_q;
    win_cnt_d = (!boot_s || !por_n_q) ? '0 : (tick_1s && !win_done) ? win_cnt_q + 8'd1 : win_cnt_q;
  end
  // Boot-image FSM; failover outranks pending update requests
  always_comb begin
    state_d = state_q;
    fatal_d = fatal_q;
    fire    = 1'b0;
    if (por_n_q)
      case (state_q)
        MAIN_BOOT:
          if (win_done && hb_lost) begin
            state_d = SECOND_BOOT;
            fire    = 1'b1;
          end else if (win_done && req_q[1]) state_d = UPD_SECOND;
        SECOND_BOOT:
          if (req_q[2]) state_d = UPD_MAIN;
          else if (win_done && hb_lost) fatal_d = 1'b1;
        default:
          if (req_q[0]) begin
            state_d = MAIN_BOOT;
            fire    = 1'b1;
          end
      endcase
  end
  // Request flags, POR pulse timer and CS select that only moves while the bus is idle
  always_comb begin
    req_d     = (state_d != state_q) ? '0 : req_q | upd_fall;
    por_cnt_d = fire ? POR_MAX : (!por_n_q && tick_1ms && por_cnt_q != 8'd0) ? por_cnt_q - 8'd1 : por_cnt_q;
    por_n_d   = fire ? 1'b0 : (!por_n_q && por_cnt_q == 8'd0) ? 1'b1 : por_n_q;
    sel_d     = csn_s ? sel : sel_q;
  end
  // State registers
  always_ff @(posedge clk or negedge rst_l)
    if (!rst_l) begin
      sync1_q   <= 6'b000111;
      sync2_q   <= 6'b000111;
      prev_q    <= 4'b0111;
      hb_cnt_q  <= '0;
      win_cnt_q <= '0;
      por_cnt_q <= '0;
      req_q     <= '0;
      state_q   <= MAIN_BOOT;
      por_n_q   <= 1'b1;
      fatal_q   <= 1'b0;
      sel_q     <= 1'b0;
    end else begin
      sync1_q   <= {heartbeat, boot_rst_n, qspi_csn_in, upd_main_n, upd_second_n, upd_done_n};
      sync2_q   <= sync1_q;
      prev_q    <= {sync2_q[5], sync2_q[2:0]};
      hb_cnt_q  <= hb_cnt_d;
      win_cnt_q <= win_cnt_d;
      por_cnt_q <= por_cnt_d;
      req_q     <= req_d;
      state_q   <= state_d;
      por_n_q   <= por_n_d;
      fatal_q   <= fatal_d;
      sel_q     <= sel_d;
    end
endmodule
